// File: rtl/pointer_chase_memory.sv
// Word-addressed RAM with a linked-list walker: each word is a pointer, next = (word + Offset) mod Depth.
// One hop per clock; the walk ends after MaxSteps hops, on returning to the start address, or on Abort.
module pointer_chase_memory #(
    parameter int WordSize     = 32,
    parameter int AddressWidth = 8,
    parameter int CountWidth   = 8
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic                    Write,
    input  logic [AddressWidth-1:0] WriteAddress,
    input  logic [WordSize-1:0]     WriteData,
    input  logic                    Start,
    input  logic [AddressWidth-1:0] StartAddress,
    input  logic [AddressWidth-1:0] Offset,
    input  logic [CountWidth-1:0]   MaxSteps,
    input  logic                    Abort,
    output logic                    Busy,
    output logic                    Valid,
    output logic [AddressWidth-1:0] Address,
    output logic [WordSize-1:0]     Data,
    output logic [CountWidth-1:0]   StepCount,
    output logic                    Done,
    output logic                    Loop,
    output logic                    WriteError
);
    localparam int Depth = 2 ** AddressWidth;

    typedef enum logic {IDLE, WALK} state_t;

    state_t                  state_reg;
    logic [AddressWidth-1:0] start_addr_reg;
    logic [AddressWidth-1:0] offset_reg;
    logic [CountWidth-1:0]   max_steps_reg;
    logic [AddressWidth-1:0] ptr_reg;
    logic [CountWidth-1:0]   cnt_reg;

    logic [WordSize-1:0]     mem [Depth];

    logic [WordSize-1:0]     rd_word;
    logic [AddressWidth-1:0] ptr_next;
    logic [CountWidth-1:0]   cnt_next;
    logic                    hit_start;
    logic                    hit_max;
    logic                    write_en;

    // Only the low address bits of a word take part in the pointer; the add wraps mod Depth.
    assign rd_word   = mem[ptr_reg];
    assign ptr_next  = rd_word[AddressWidth-1:0] + offset_reg;
    assign cnt_next  = cnt_reg + CountWidth'(1);
    assign hit_start = (ptr_next == start_addr_reg);
    assign hit_max   = (cnt_next == max_steps_reg);
    assign write_en  = Write && (state_reg == IDLE) && ResetN;

    // RAM contents survive reset, so the array lives outside the reset domain.
    always_ff @(posedge Clock) begin
        if (write_en) begin
            mem[WriteAddress] <= WriteData;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_reg      <= IDLE;
            start_addr_reg <= '0;
            offset_reg     <= '0;
            max_steps_reg  <= '0;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            Busy           <= 1'b0;
            Valid          <= 1'b0;
            Address        <= '0;
            Data           <= '0;
            StepCount      <= '0;
            Done           <= 1'b0;
            Loop           <= 1'b0;
            WriteError     <= 1'b0;
        end else begin
            Valid      <= 1'b0;
            Done       <= 1'b0;
            WriteError <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        start_addr_reg <= StartAddress;
                        offset_reg     <= Offset;
                        max_steps_reg  <= MaxSteps;
                        ptr_reg        <= StartAddress;
                        cnt_reg        <= '0;
                        Loop           <= 1'b0;
                        if (MaxSteps != '0) begin
                            state_reg <= WALK;
                            Busy      <= 1'b1;
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                end
                WALK: begin
                    WriteError <= Write;
                    if (Abort) begin
                        state_reg <= IDLE;
                        Busy      <= 1'b0;
                    end else begin
                        Valid     <= 1'b1;
                        Address   <= ptr_reg;
                        Data      <= rd_word;
                        StepCount <= cnt_next;
                        ptr_reg   <= ptr_next;
                        cnt_reg   <= cnt_next;
                        // Returning to the start wins over the hop limit for Loop.
                        if (hit_start || hit_max) begin
                            state_reg <= IDLE;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                            Loop      <= hit_start;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pointer_chase_memory.sv
// Randomised bench for pointer_chase_memory: a chain-walking reference model predicts every cycle's outputs.
module tb_pointer_chase_memory;
    localparam int AW = 3;
    localparam int WS = 32;
    localparam int CW = 8;

    logic          Clock = 1'b0;
    logic          ResetN;
    logic          Write;
    logic [AW-1:0] WriteAddress;
    logic [WS-1:0] WriteData;
    logic          Start;
    logic [AW-1:0] StartAddress;
    logic [AW-1:0] Offset;
    logic [CW-1:0] MaxSteps;
    logic          Abort;
    logic          Busy;
    logic          Valid;
    logic [AW-1:0] Address;
    logic [WS-1:0] Data;
    logic [CW-1:0] StepCount;
    logic          Done;
    logic          Loop;
    logic          WriteError;

    always #5 Clock = ~Clock;

    pointer_chase_memory #(.WordSize(WS), .AddressWidth(AW), .CountWidth(CW)) dut (
        .Clock(Clock), .ResetN(ResetN), .Write(Write), .WriteAddress(WriteAddress),
        .WriteData(WriteData), .Start(Start), .StartAddress(StartAddress), .Offset(Offset),
        .MaxSteps(MaxSteps), .Abort(Abort), .Busy(Busy), .Valid(Valid), .Address(Address),
        .Data(Data), .StepCount(StepCount), .Done(Done), .Loop(Loop), .WriteError(WriteError)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic        exp_busy, exp_valid, exp_done, exp_loop, exp_werr, exp_zero;
    logic [31:0] exp_addr, exp_data, exp_cnt;

    logic [WS-1:0] model_mem [8];
    int            mq_addr [$];
    logic [WS-1:0] mq_data [$];
    bit            m_loop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Follow the chain from sa for up to ms hops, stopping early on a return to sa.
    function automatic void model_walk(input int sa, input int off, input int ms);
        int cur;
        int nxt;
        mq_addr.delete();
        mq_data.delete();
        m_loop = 0;
        cur = sa;
        for (int i = 1; i <= ms; i++) begin
            mq_addr.push_back(cur);
            mq_data.push_back(model_mem[cur]);
            nxt = (int'(model_mem[cur] % 32'd8) + off) % 8;
            if (nxt == sa) begin
                m_loop = 1;
                break;
            end
            cur = nxt;
        end
    endfunction

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("busy", {31'd0, Busy}, {31'd0, exp_busy});
            chk("valid", {31'd0, Valid}, {31'd0, exp_valid});
            chk("done", {31'd0, Done}, {31'd0, exp_done});
            chk("loop", {31'd0, Loop}, {31'd0, exp_loop});
            chk("write_error", {31'd0, WriteError}, {31'd0, exp_werr});
            if (exp_valid || exp_zero) begin
                chk("address", 32'(Address), exp_addr);
                chk("data", Data, exp_data);
                chk("step_count", 32'(StepCount), exp_cnt);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_write(input int a, input logic [WS-1:0] d, input bit abort_too);
        Write = 1'b1;
        WriteAddress = AW'(a);
        WriteData = d;
        Abort = abort_too;
        step();
        Write = 1'b0;
        Abort = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_walk(input int sa, input int off, input int ms, input int abort_at,
                           input int wr_at, input int reset_at, input bit same_w,
                           input int wa, input logic [WS-1:0] wd);
        int n;
        if (same_w) begin
            Write = 1'b1;
            WriteAddress = AW'(wa);
            WriteData = wd;
            model_mem[wa] = wd;
        end
        Start = 1'b1;
        StartAddress = AW'(sa);
        Offset = AW'(off);
        MaxSteps = CW'(ms);
        model_walk(sa, off, ms);
        n = mq_addr.size();
        step();
        Start = 1'b0;
        Write = 1'b0;
        exp_zero = 0;
        exp_loop = 0;
        exp_valid = 0;
        exp_werr = 0;
        exp_done = (ms == 0);
        exp_busy = (ms != 0);
        for (int i = 1; i <= n; i++) begin
            if (i == reset_at) begin
                ResetN = 1'b0;
                {exp_busy, exp_valid, exp_done, exp_loop, exp_werr} = '0;
                exp_addr = 0;
                exp_data = 0;
                exp_cnt = 0;
                exp_zero = 1;
                repeat (2) step();
                ResetN = 1'b1;
                step();
                return;
            end
            Abort = (i == abort_at);
            if (i == wr_at) begin
                Write = 1'b1;
                WriteAddress = AW'(wa);
                WriteData = wd;
            end
            if ($urandom_range(0, 3) == 0) begin
                Start = 1'b1;
                StartAddress = AW'($urandom);
                Offset = AW'($urandom);
                MaxSteps = CW'($urandom);
            end
            step();
            Abort = 1'b0;
            Write = 1'b0;
            Start = 1'b0;
            exp_werr = (i == wr_at);
            if (i == abort_at) begin
                exp_busy = 0;
                exp_valid = 0;
                exp_done = 0;
                break;
            end
            exp_valid = 1;
            exp_addr = 32'(mq_addr[i-1]);
            exp_data = mq_data[i-1];
            exp_cnt = 32'(i);
            exp_done = (i == n);
            exp_loop = (i == n) && m_loop;
            exp_busy = (i != n);
        end
        step();
        exp_valid = 0;
        exp_done = 0;
        exp_werr = 0;
        exp_busy = 0;
    endtask

    initial begin
        int lit_a [6];
        int lit_d [6];
        int ms, ab, wr;
        lit_a = '{0, 5, 6, 7, 1, 2};
        lit_d = '{4, 5, 6, 0, 1, 3};
        ResetN = 1'b1;
        Write = 1'b0; WriteAddress = '0; WriteData = '0;
        Start = 1'b0; StartAddress = '0; Offset = '0; MaxSteps = '0; Abort = 1'b0;
        {exp_busy, exp_valid, exp_done, exp_loop, exp_werr} = '0;
        exp_addr = 0; exp_data = 0; exp_cnt = 0; exp_zero = 1;
        #2 ResetN = 1'b0;
        chk_en = 1;
        repeat (2) step();
        ResetN = 1'b1;
        step();

        // Table 4,1,3,4,2,5,6,0; one write also carries a stray Abort that must be ignored.
        idle_write(0, 4, 0); idle_write(1, 1, 0); idle_write(2, 3, 1); idle_write(3, 4, 0);
        idle_write(4, 2, 0); idle_write(5, 5, 0); idle_write(6, 6, 0); idle_write(7, 0, 0);

        model_walk(0, 1, 6);
        chk("pin1_len", 32'(mq_addr.size()), 32'd6);
        chk("pin1_loop", {31'd0, m_loop}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("pin1_addr", 32'(mq_addr[i]), 32'(lit_a[i]));
            chk("pin1_data", mq_data[i], 32'(lit_d[i]));
        end
        model_walk(4, 0, 10);
        chk("pin2_len", 32'(mq_addr.size()), 32'd3);
        chk("pin2_loop", {31'd0, m_loop}, 32'd1);
        chk("pin2_addr3", 32'(mq_addr[2]), 32'd3);

        do_walk(0, 1, 6, 0, 0, 0, 0, 0, 0);
        do_walk(4, 0, 10, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        do_walk(2, 3, 0, 0, 0, 0, 0, 0, 0);
        do_walk(0, 1, 6, 0, 2, 0, 0, 1, 7);
        do_walk(0, 1, 6, 0, 0, 0, 0, 0, 0);
        do_walk(0, 1, 6, 0, 0, 0, 1, 6, 3);
        idle_write(6, 6, 0);
        do_walk(0, 1, 6, 3, 0, 0, 0, 0, 0);
        do_walk(0, 1, 6, 0, 0, 4, 0, 0, 0);
        do_walk(0, 1, 6, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++)
                idle_write($urandom_range(0, 7),
                           ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : 32'($urandom), 0);
            ms = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            if ($urandom_range(0, 15) == 0) ms = 200;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            wr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            do_walk($urandom_range(0, 7), $urandom_range(0, 7), ms, ab, wr, 0,
                    ($urandom_range(0, 4) == 0), $urandom_range(0, 7), 32'($urandom_range(0, 15)));
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
